// File: rtl/uart_pkg.sv
// uart_pkg: shared state type and constants for the UART receiver
package uart_pkg;
  localparam int UART_CLK_DIV_DEFAULT = 10417;
  localparam int UART_DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAITHI} uart_rx_state_t;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for rxd plus previous-value flop for falling-edge detect
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic line,
  output logic fall
);
  logic s1, prev;
  // flops reset high so the idle line level is assumed after reset
  always_ff @(posedge clk) {s1, line, prev} <= rst ? 3'b111 : {rxd, s1, line};
  assign fall = prev & ~line;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with one-cycle valid/error pulses; define UART_RX_PARITY_EN for 8E1
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_DIV = UART_CLK_DIV_DEFAULT,
  parameter int HALF = CLK_DIV / 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rxd,
  output logic [UART_DATA_BITS-1:0] dout,
  output logic                      valid,
  output logic                      frame_err,
  output logic                      parity_err,
  output logic                      busy
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] HM = CW'(HALF - 1);
  localparam logic [CW-1:0] FM = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BM = BW'(UART_DATA_BITS - 1);
  uart_rx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bits, bits_n;
  logic [UART_DATA_BITS-1:0] sh, sh_n, dout_n;
  logic valid_n, frame_err_n, line, fall, tick;
  uart_rx_sync u_sync (.clk, .rst, .rxd, .line, .fall);
  assign busy = state != IDLE;
  assign tick = cnt == FM;
`ifdef UART_RX_PARITY_EN
  logic par, par_n, parity_err_n;
  // parity mismatch flag held from the parity sample to the stop sample
  always_ff @(posedge clk) {par, parity_err} <= rst ? 2'b00 : {par_n, parity_err_n};
`else
  assign parity_err = 1'b0;
`endif
  // state, counters, shift register and registered status pulses
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bits <= '0;
      sh <= '0;
      dout <= '0;
      valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bits <= bits_n;
      sh <= sh_n;
      dout <= dout_n;
      valid <= valid_n;
      frame_err <= frame_err_n;
    end
  // next-state: sample start at mid-bit, then every full bit period after that
  always_comb begin
    state_n = state;
    cnt_n = cnt + CW'(1);
    bits_n = bits;
    sh_n = sh;
    dout_n = dout;
    valid_n = 1'b0;
    frame_err_n = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n = par;
    parity_err_n = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        state_n = fall ? START : IDLE;
      end
      START: if (cnt == HM) begin
        cnt_n = '0;
        bits_n = '0;
        state_n = line ? IDLE : DATA;
      end
      DATA: if (tick) begin
        cnt_n = '0;
        sh_n = {line, sh[UART_DATA_BITS-1:1]};
        bits_n = bits + BW'(1);
`ifdef UART_RX_PARITY_EN
        state_n = bits == BM ? PARITY : DATA;
`else
        state_n = bits == BM ? STOP : DATA;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        cnt_n = '0;
        par_n = line != ^sh;
        state_n = STOP;
      end
`endif
      STOP: if (tick) begin
        cnt_n = '0;
        state_n = line ? IDLE : WAITHI;
        frame_err_n = !line;
`ifdef UART_RX_PARITY_EN
        parity_err_n = line & par;
        valid_n = line & !par;
`else
        valid_n = line;
`endif
        dout_n = valid_n ? sh : dout;
      end
      WAITHI: begin
        cnt_n = '0;
        state_n = line ? IDLE : WAITHI;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed table-driven bench for uart_rx at CLK_DIV=16, HALF=8
module tb_uart_rx;
  localparam int CD = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FL = FB * CD;
  localparam int PT = 8 + CD * (FB - 1) + 3;
  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       ev;
    logic       ef;
    logic [7:0] ed;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, rxd = 1'b1;
  logic [7:0] dout;
  logic valid, frame_err, parity_err, busy;
  int cyc = 0, n_chk = 0, n_err = 0;
  int nv = 0, nf = 0, np = 0, tv = 0, tv_prev = 0, tf = 0, tp = 0;
  logic [7:0] dv = 0, dv_prev = 0;
  vec_t tbl [6];
  uart_rx #(.CLK_DIV(CD), .HALF(8)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .dout(dout), .valid(valid),
    .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1;
    if (valid) begin
      nv++;
      tv_prev = tv;
      tv = cyc;
      dv_prev = dv;
      dv = dout;
    end
    if (frame_err) begin
      nf++;
      tf = cyc;
    end
    if (parity_err) begin
      np++;
      tp = cyc;
    end
  end
  task automatic chk(input string n, input int a, input int e);
    n_chk++;
    if (a != e) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  function automatic logic [FB-1:0] frm(input logic [7:0] d, input logic stop);
`ifdef UART_RX_PARITY_EN
    return {stop, ^d, d, 1'b0};
`else
    return {stop, d, 1'b0};
`endif
  endfunction
  task automatic send(input logic [FB-1:0] f, output int t0);
    t0 = cyc;
    for (int i = 0; i < FB; i++) begin
      rxd = f[i];
      repeat (CD) @(negedge clk);
    end
  endtask
  initial begin
    int t0, t1, v0, f0, p0;
    logic [7:0] d0;
    tbl[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5};
    tbl[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5};
    tbl[2] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[3] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF};
    tbl[4] = '{8'h81, 1'b1, 1'b1, 1'b0, 8'h81};
    tbl[5] = '{8'h6E, 1'b1, 1'b1, 1'b0, 8'h6E};
    repeat (3) @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      v0 = nv; f0 = nf; p0 = np;
      send(frm(tbl[i].d, tbl[i].stop), t0);
      rxd = 1'b1;
      repeat (20) @(negedge clk);
      chk("vec_valid_cnt", nv - v0, int'(tbl[i].ev));
      chk("vec_ferr_cnt", nf - f0, int'(tbl[i].ef));
      chk("vec_perr_cnt", np - p0, 0);
      chk("vec_pulse_time", (tbl[i].ev ? tv : tf) - t0, PT);
      chk("vec_dout", dout, tbl[i].ed);
      chk("vec_busy_idle", busy, 0);
    end
    d0 = dout; v0 = nv; f0 = nf; p0 = np;
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_busy_hi", busy, 1);
    repeat (20) @(negedge clk);
    chk("glitch_busy_lo", busy, 0);
    chk("glitch_pulses", (nv - v0) + (nf - f0) + (np - p0), 0);
    chk("glitch_dout", dout, d0);
    d0 = dout; v0 = nv; f0 = nf;
    send(frm(8'h3C, 1'b0), t0);
    repeat (40) @(negedge clk);
    chk("fe_ferr_cnt", nf - f0, 1);
    chk("fe_time", tf - t0, PT);
    chk("fe_valid_cnt", nv - v0, 0);
    chk("fe_dout", dout, d0);
    chk("fe_busy_held", busy, 1);
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    chk("fe_busy_release", busy, 0);
    send(frm(8'h96, 1'b1), t0);
    repeat (20) @(negedge clk);
    chk("fe_next_valid_cnt", nv - v0, 1);
    chk("fe_next_time", tv - t0, PT);
    chk("fe_next_dout", dout, 8'h96);
    v0 = nv;
    send(frm(8'h00, 1'b1), t0);
    send(frm(8'hFF, 1'b1), t1);
    repeat (20) @(negedge clk);
    chk("b2b_valid_cnt", nv - v0, 2);
    chk("b2b_first_time", tv_prev - t0, PT);
    chk("b2b_gap", tv - tv_prev, FL);
    chk("b2b_first_data", dv_prev, 8'h00);
    chk("b2b_second_data", dv, 8'hFF);
    v0 = nv; f0 = nf; p0 = np;
    rxd = 1'b0;
    repeat (5 * CD) @(negedge clk);
    rxd = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_dout", dout, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_valid", valid, 0);
    chk("mrst_ferr", frame_err, 0);
    chk("mrst_perr", parity_err, 0);
    repeat (6 * CD) @(negedge clk);
    chk("mrst_no_pulse", (nv - v0) + (nf - f0) + (np - p0), 0);
    send(frm(8'h5A, 1'b1), t0);
    repeat (20) @(negedge clk);
    chk("mrst_next_cnt", nv - v0, 1);
    chk("mrst_next_time", tv - t0, PT);
    chk("mrst_next_dout", dout, 8'h5A);
`ifdef UART_RX_PARITY_EN
    d0 = dout; v0 = nv; p0 = np;
    send({1'b1, 1'b0, 8'h07, 1'b0}, t0);
    repeat (20) @(negedge clk);
    chk("par_bad_cnt", np - p0, 1);
    chk("par_bad_time", tp - t0, PT);
    chk("par_bad_valid", nv - v0, 0);
    chk("par_bad_dout", dout, d0);
    send({1'b1, 1'b1, 8'h07, 1'b0}, t0);
    repeat (20) @(negedge clk);
    chk("par_ok_valid", nv - v0, 1);
    chk("par_ok_perr", np - p0, 1);
    chk("par_ok_dout", dout, 8'h07);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, 8N1 by default. It recovers bytes from the `rxd` line at the same bit rate the team's clock divider produces: default 100 MHz / 9600 baud, with a full bit period of 10417 clocks. It sits between the board UART pin and the byte consumer, and presents each received byte as a one-cycle valid pulse. It is the receive end of the serial link whose bit timing is generated by the divider.

## Interface
Parameters:
- `CLK_DIV`, 10417: clocks per bit period. Must be ≥ 4.
- `HALF`, `CLK_DIV/2`: clocks from start-edge detection to the start-bit mid-point. Integer division.

Ports:
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset. One clock; reset is synchronous and active-high.
- `rxd`, input, 1: asynchronous serial line. Idle high, LSB first.
- `dout`, output, 8: last good byte. Held until the next good frame.
- `valid`, output, 1: one-cycle pulse when `dout` updates.
- `frame_err`, output, 1: one-cycle pulse when the stop bit is sampled as 0.
- `parity_err`, output, 1: one-cycle pulse on an even-parity mismatch. Constant 0 without the macro.
- `busy`, output, 1: high in every state except IDLE.

## Operation
- `rxd` passes through a 2-flop synchronizer; both flops reset to 1. A third flop holds the previous synced value for edge detection.
- States: IDLE, START, DATA, PARITY (macro only), STOP, WAITHI.
  - **IDLE:** on a synced 1→0 transition, go to START and clear the bit counter `cnt`.
  - **START:** when `cnt == HALF-1`, sample the line.
    - Sample 0: go to DATA and clear `cnt`.
    - Sample 1: treat as a glitch and return to IDLE with no pulse.
  - **DATA:** when `cnt == CLK_DIV-1`, sample one bit into a shift register, LSB first, then clear `cnt`. After the 8th bit, go to PARITY or STOP.
  - **PARITY:** sample once at `cnt == CLK_DIV-1`. Mismatch condition: sampled bit ≠ XOR of the 8 data bits.
  - **STOP:** sample at `cnt == CLK_DIV-1`.
    - Sample 1 with no parity mismatch: load `dout`, pulse `valid`, go to IDLE.
    - Sample 1 with a parity mismatch: pulse `parity_err`, leave `dout` unchanged, no `valid`, go to IDLE.
    - Sample 0: pulse `frame_err`, leave `dout` unchanged, no `valid`, go to WAITHI.
  - **WAITHI:** stay until the synced line is 1, then go to IDLE. This prevents a break condition (line held low) from being read as repeated 0x00 frames.
- `cnt` width is `$clog2(CLK_DIV)`. `cnt` never wraps; it is cleared on every sample.
- Returning to IDLE at the stop-bit mid-point allows back-to-back frames. A start edge arriving in the second half of the stop bit is detected.
- Reset asserted mid-frame: next cycle the block is in IDLE, all outputs are at reset values, and the partial byte is discarded.
- Line low across reset release: the synchronizer resets to 1, so a falling edge is seen. The resulting frame is validated normally; a held-low line ends in `frame_err` followed by WAITHI.

## Timing
- Reset values:
  - `dout` = 8'h00.
  - `valid`, `frame_err`, `parity_err`, `busy` = 0.
  - State = IDLE.
  - Synchronizer flops = 1.
- Pin-to-detect latency: 2 clocks.
- Let D be the cycle in which IDLE sees the synced falling edge. Then:
  - `valid`, `frame_err` or `parity_err` is asserted, registered, in cycle D + HALF + 9·CLK_DIV + 1.
  - With the macro, the same pulse is in cycle D + HALF + 10·CLK_DIV + 1.
- Every status pulse lasts exactly 1 cycle.
- `valid` and any error pulse are mutually exclusive within a frame.
- `busy` rises in cycle D+1. It falls in the cycle the pulse is asserted, or on leaving WAITHI.
- There is no backpressure: the consumer must take `dout` within one frame time.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state is compiled in.
  - Frames are 8E1: 11 bits.
  - `parity_err` is driven as described above.
- `UART_RX_PARITY_EN` undefined:
  - No PARITY state.
  - Frames are 8N1: 10 bits.
  - `parity_err` is tied to 0.

## Structure
- Package `uart_pkg` holds:
  - the state enum `uart_rx_state_t`;
  - the localparam `UART_CLK_DIV_DEFAULT = 10417`;
  - the localparam `UART_DATA_BITS = 8`.
- Sub-module `uart_rx_sync` contains the 2-flop synchronizer, the previous-value flop and the `fall` output. It is reset to 1.

## Test plan
Benches use `CLK_DIV = 16`, `HALF = 8`.
- **Good frame:** send 0xA5 as 8N1. Required: `valid` for 1 cycle at D+153, `dout` = 8'hA5, no error pulse.
- **Glitch:** `rxd` low for 3 clocks, then high. Required: START aborts at mid-point, `busy` returns to 0, no pulse, `dout` unchanged.
- **Framing error:** send 0x3C with stop bit 0, line held low 40 more clocks. Required: `frame_err` pulse, no `valid`, `dout` unchanged, `busy` stays high until the line returns high, then exactly one new frame is received.
- **Back-to-back:** send 0x00 then 0xFF with no idle gap. Required: two `valid` pulses 160 clocks apart, with `dout` = 00 then FF.
- **Reset mid-frame:** assert `rst` during data bit 4 for 1 cycle. Required: all outputs 0 next cycle, no pulse for the aborted frame, next full frame 0x5A received correctly.
- **Parity (macro defined):** send 0x07 with parity bit 0. Required: `parity_err` pulse at D+169, no `valid`. Send 0x07 with parity bit 1. Required: `valid` pulse, `dout` = 8'h07.
